// File: rtl/axi_pkg.sv
// Shared AXI3 field widths, encodings, bundle structs and arbiter FSM state types
// used by the two-port AXI master arbiter.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic [ID_W-1:0] ID_DCACHE = 4'h0;
  localparam logic [ID_W-1:0] ID_ICACHE = 4'h1;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
  } ax_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: grant latched on start, last grant recorded on done.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       start,
  input  logic       done,
  output logic       gnt
);

  logic last_gnt;
  logic next_gnt;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    next_gnt = gnt;
    case (req)
      2'b01:   next_gnt = 1'b0;
      2'b10:   next_gnt = 1'b1;
      2'b11:   next_gnt = ~last_gnt;
      default: next_gnt = gnt;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      if (start) gnt      <= next_gnt;
      if (done)  last_gnt <= gnt;
    end
  end

endmodule

// File: rtl/axi_arbiter_2to1.sv
// Shares one AXI3 master port between the dcache (s0) and icache (s1) bridges; read and
// write channels are arbitrated independently and a grant is held for the whole burst.
module axi_arbiter_2to1
  import axi_pkg::*;
#(
  parameter logic [ID_W-1:0] S0_ID = 4'h0,
  parameter logic [ID_W-1:0] S1_ID = 4'h1
) (
  input  logic clk,
  input  logic rstn,
  input  logic [ID_W-1:0] s0_arid, input logic [ADDR_W-1:0] s0_araddr, input logic [LEN_W-1:0] s0_arlen,
  input  logic [2:0] s0_arsize, input logic [1:0] s0_arburst, input logic s0_arlock,
  input  logic [3:0] s0_arcache, input logic [2:0] s0_arprot, input logic s0_arvalid, output logic s0_arready,
  output logic [ID_W-1:0] s0_rid, output logic [DATA_W-1:0] s0_rdata, output logic [1:0] s0_rresp,
  output logic s0_rlast, output logic s0_rvalid, input logic s0_rready,
  input  logic [ID_W-1:0] s0_awid, input logic [ADDR_W-1:0] s0_awaddr, input logic [LEN_W-1:0] s0_awlen,
  input  logic [2:0] s0_awsize, input logic [1:0] s0_awburst, input logic s0_awlock,
  input  logic [3:0] s0_awcache, input logic [2:0] s0_awprot, input logic s0_awvalid, output logic s0_awready,
  input  logic [ID_W-1:0] s0_wid, input logic [DATA_W-1:0] s0_wdata, input logic [STRB_W-1:0] s0_wstrb,
  input  logic s0_wlast, input logic s0_wvalid, output logic s0_wready,
  output logic [ID_W-1:0] s0_bid, output logic [1:0] s0_bresp, output logic s0_bvalid, input logic s0_bready,
  input  logic [ID_W-1:0] s1_arid, input logic [ADDR_W-1:0] s1_araddr, input logic [LEN_W-1:0] s1_arlen,
  input  logic [2:0] s1_arsize, input logic [1:0] s1_arburst, input logic s1_arlock,
  input  logic [3:0] s1_arcache, input logic [2:0] s1_arprot, input logic s1_arvalid, output logic s1_arready,
  output logic [ID_W-1:0] s1_rid, output logic [DATA_W-1:0] s1_rdata, output logic [1:0] s1_rresp,
  output logic s1_rlast, output logic s1_rvalid, input logic s1_rready,
  input  logic [ID_W-1:0] s1_awid, input logic [ADDR_W-1:0] s1_awaddr, input logic [LEN_W-1:0] s1_awlen,
  input  logic [2:0] s1_awsize, input logic [1:0] s1_awburst, input logic s1_awlock,
  input  logic [3:0] s1_awcache, input logic [2:0] s1_awprot, input logic s1_awvalid, output logic s1_awready,
  input  logic [ID_W-1:0] s1_wid, input logic [DATA_W-1:0] s1_wdata, input logic [STRB_W-1:0] s1_wstrb,
  input  logic s1_wlast, input logic s1_wvalid, output logic s1_wready,
  output logic [ID_W-1:0] s1_bid, output logic [1:0] s1_bresp, output logic s1_bvalid, input logic s1_bready,
  output logic [ID_W-1:0] m_arid, output logic [ADDR_W-1:0] m_araddr, output logic [LEN_W-1:0] m_arlen,
  output logic [2:0] m_arsize, output logic [1:0] m_arburst, output logic m_arlock,
  output logic [3:0] m_arcache, output logic [2:0] m_arprot, output logic m_arvalid, input logic m_arready,
  input  logic [ID_W-1:0] m_rid, input logic [DATA_W-1:0] m_rdata, input logic [1:0] m_rresp,
  input  logic m_rlast, input logic m_rvalid, output logic m_rready,
  output logic [ID_W-1:0] m_awid, output logic [ADDR_W-1:0] m_awaddr, output logic [LEN_W-1:0] m_awlen,
  output logic [2:0] m_awsize, output logic [1:0] m_awburst, output logic m_awlock,
  output logic [3:0] m_awcache, output logic [2:0] m_awprot, output logic m_awvalid, input logic m_awready,
  output logic [ID_W-1:0] m_wid, output logic [DATA_W-1:0] m_wdata, output logic [STRB_W-1:0] m_wstrb,
  output logic m_wlast, output logic m_wvalid, input logic m_wready,
  input  logic [ID_W-1:0] m_bid, input logic [1:0] m_bresp, input logic m_bvalid, output logic m_bready
);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic      rgnt, wgnt;
  logic      rd_start, rd_done, wr_start, wr_done;

  ax_t s0_ar, s1_ar, s0_aw, s1_aw, m_ar, m_aw;
  r_t  m_r, s0_r, s1_r;
  w_t  s0_w, s1_w, m_w;
  b_t  m_b, s0_b, s1_b;

  // IDs pass through untouched; the expected-ID parameters document the integration only.
  logic unused_ids;
  assign unused_ids = ^{S0_ID, S1_ID};

  assign s0_ar = {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot};
  assign s1_ar = {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot};
  assign s0_aw = {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot};
  assign s1_aw = {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot};
  assign s0_w  = {s0_wid, s0_wdata, s0_wstrb, s0_wlast};
  assign s1_w  = {s1_wid, s1_wdata, s1_wstrb, s1_wlast};
  assign m_r   = {m_rid, m_rdata, m_rresp, m_rlast};
  assign m_b   = {m_bid, m_bresp};

  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} = m_ar;
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} = m_aw;
  assign {m_wid, m_wdata, m_wstrb, m_wlast} = m_w;
  assign {s0_rid, s0_rdata, s0_rresp, s0_rlast} = s0_r;
  assign {s1_rid, s1_rdata, s1_rresp, s1_rlast} = s1_r;
  assign {s0_bid, s0_bresp} = s0_b;
  assign {s1_bid, s1_bresp} = s1_b;

  rr_arb2 u_rd_arb (
    .clk(clk), .rstn(rstn), .req({s1_arvalid, s0_arvalid}),
    .start(rd_start), .done(rd_done), .gnt(rgnt)
  );

  rr_arb2 u_wr_arb (
    .clk(clk), .rstn(rstn), .req({s1_awvalid, s0_awvalid}),
    .start(wr_start), .done(wr_done), .gnt(wgnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next  = rd_state;
    rd_start = 1'b0;
    rd_done  = 1'b0;
    case (rd_state)
      RD_IDLE: if (s0_arvalid || s1_arvalid) begin rd_start = 1'b1; rd_next = RD_ADDR; end
      RD_ADDR: if (m_arvalid && m_arready) rd_next = RD_DATA;
      RD_DATA: if (m_rvalid && m_rready && m_rlast) begin rd_done = 1'b1; rd_next = RD_IDLE; end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next  = wr_state;
    wr_start = 1'b0;
    wr_done  = 1'b0;
    case (wr_state)
      WR_IDLE: if (s0_awvalid || s1_awvalid) begin wr_start = 1'b1; wr_next = WR_ADDR; end
      WR_ADDR: if (m_awvalid && m_awready) wr_next = WR_DATA;
      WR_DATA: if (m_wvalid && m_wready && m_wlast) wr_next = WR_RESP;
      WR_RESP: if (m_bvalid && m_bready) begin wr_done = 1'b1; wr_next = WR_IDLE; end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Read routing is steered purely by the registered grant; ungranted ports stay quiet.
  always_comb begin
    m_ar = '0; m_arvalid = 1'b0; s0_arready = 1'b0; s1_arready = 1'b0;
    s0_r = '0; s1_r = '0; s0_rvalid = 1'b0; s1_rvalid = 1'b0; m_rready = 1'b0;
    if (rd_state == RD_ADDR) begin
      m_ar       = rgnt ? s1_ar : s0_ar;
      m_arvalid  = rgnt ? s1_arvalid : s0_arvalid;
      s0_arready = !rgnt && m_arready;
      s1_arready = rgnt && m_arready;
    end
    if (rd_state == RD_DATA) begin
      if (rgnt) begin s1_r = m_r; s1_rvalid = m_rvalid; m_rready = s1_rready; end
      else      begin s0_r = m_r; s0_rvalid = m_rvalid; m_rready = s0_rready; end
    end
  end

  always_comb begin
    m_aw = '0; m_awvalid = 1'b0; s0_awready = 1'b0; s1_awready = 1'b0;
    m_w = '0; m_wvalid = 1'b0; s0_wready = 1'b0; s1_wready = 1'b0;
    s0_b = '0; s1_b = '0; s0_bvalid = 1'b0; s1_bvalid = 1'b0; m_bready = 1'b0;
    if (wr_state == WR_ADDR) begin
      m_aw       = wgnt ? s1_aw : s0_aw;
      m_awvalid  = wgnt ? s1_awvalid : s0_awvalid;
      s0_awready = !wgnt && m_awready;
      s1_awready = wgnt && m_awready;
    end
    if (wr_state == WR_DATA) begin
      m_w       = wgnt ? s1_w : s0_w;
      m_wvalid  = wgnt ? s1_wvalid : s0_wvalid;
      s0_wready = !wgnt && m_wready;
      s1_wready = wgnt && m_wready;
    end
    if (wr_state == WR_RESP) begin
      if (wgnt) begin s1_b = m_b; s1_bvalid = m_bvalid; m_bready = s1_bready; end
      else      begin s0_b = m_b; s0_bvalid = m_bvalid; m_bready = s0_bready; end
    end
  end

endmodule

// File: doc/axi_arbiter_2to1.md
# axi_arbiter_2to1

Shares the single external AXI master port between the instruction-side and data-side cache bridges. Read and write channels are arbitrated independently with round-robin fairness. A grant is held for a whole burst transaction: AR through the last R beat, AW through the B handshake. The block sits between the two cache bridges and the SoC AXI interconnect, and supports one outstanding read and one outstanding write.

## Interface
Parameters:
- `S0_ID`, 4'h0: expected ID of slave port 0 (data cache bridge).
- `S1_ID`, 4'h1: expected ID of slave port 1 (instruction cache bridge).

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `s0_ar*`, `s1_ar*`  in/out  AXI3 AR bundle.
  - Inputs: id 4, addr 32, len 8, size 3, burst 2, lock 1, cache 4, prot 3, valid.
  - Output: ready.
- `s0_r*`, `s1_r*`  out/in  R bundle.
  - Outputs: id 4, data 32, resp 2, last, valid.
  - Input: ready.
- `s0_aw*`, `s1_aw*`  in/out  AW bundle, same field set as AR.
- `s0_w*`, `s1_w*`  in/out  W bundle.
  - Inputs: id 4, data 32, strb 4, last, valid.
  - Output: ready.
- `s0_b*`, `s1_b*`  out/in  B bundle.
  - Outputs: id 4, resp 2, valid.
  - Input: ready.
- `m_ar*`, `m_r*`, `m_aw*`, `m_w*`, `m_b*`  toward interconnect. Same bundles as the slave ports with directions reversed.

## Operation
**Read FSM** (`RD_IDLE`, `RD_ADDR`, `RD_DATA`):
- `RD_IDLE`:
  - Sample `s0_arvalid` and `s1_arvalid`.
  - If any request is present, register `rgnt` and go to `RD_ADDR`.
- `RD_ADDR`:
  - Route the granted AR bundle to `m_ar*`. `m_arvalid` equals the granted slave's arvalid.
  - On `m_arvalid & m_arready`, go to `RD_DATA`.
- `RD_DATA`:
  - `m_r*` is routed to the granted slave; `m_rready` equals that slave's rready.
  - On `m_rvalid & m_rready & m_rlast`, go to `RD_IDLE` and set `rlast_gnt <= rgnt`.

**Write FSM** (`WR_IDLE`, `WR_ADDR`, `WR_DATA`, `WR_RESP`):
- Same structure as the read FSM, arbitrating on awvalid.
- `WR_DATA` routes W; exit on `m_wvalid & m_wready & m_wlast`.
- `WR_RESP` routes B; exit on `m_bvalid & m_bready` to `WR_IDLE`, updating `wlast_gnt`.

**Round-robin rule:**
- If both slaves request, grant the one not equal to `last_gnt`.
- If only one requests, grant it.

**Non-granted slave ports:**
- arready, rvalid, awready, wready and bvalid are held 0.
- Data and id outputs are don't-care but driven 0.

**Routing:** responses are steered by the registered grant, never by rid/bid. IDs are passed through unmodified.

**Reset:**
- States go to IDLE; `rlast_gnt` and `wlast_gnt` go to 1, so s0 wins the first tie.
- All valid/ready outputs are 0, and every other output is 0.
- A reset mid-burst abandons the transaction. No recovery is attempted; the system-level reset also resets the interconnect.

## Timing
- Arbitration latency is one cycle: a request first seen at edge N gives `m_arvalid` or `m_awvalid` high from cycle N+1.
- AR, AW, R, W and B forwarding is purely combinational in the active state, with zero added latency per beat.
- Back-to-back bursts incur one `RD_IDLE`/`WR_IDLE` cycle between transactions.
- Read and write run concurrently; s0 may read while s1 writes, with no coupling.
- A slave deasserting valid in ADDR state is not AXI-legal and is unsupported. The FSM simply waits.
- A W beat presented before the AW handshake is not forwarded; wready stays 0 until `WR_DATA`.

## Structure
- Shared package `axi_pkg`:
  - Bundle widths.
  - Burst encodings: FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - SIZE_4B=3'b010.
  - IDs for icache and dcache.
- One sub-module `rr_arb2`: 2-requester round-robin with registered last-grant, instantiated once for read and once for write.
- Muxing stays in the top level.

## Test plan
- Single read: s1 ARs addr 0x1FC0_0000, len 3; the slave returns 4 beats 0xA0..0xA3. Required: `m_araddr`=0x1FC0_0000 one cycle after the request, s1 receives 4 beats with rlast on the 4th, and s0 sees rvalid=0 throughout.
- Simultaneous reads after reset: s0 and s1 arvalid in the same cycle. Required: s0 is granted first. s1 is granted after s0's rlast plus one idle cycle. Then repeat the tie: s0 is granted again, since s1 was last.
- Write burst: s0 AW addr 0x8000_0040, len 3, four W beats 0x11..0x44, slave bready-delayed by 5 cycles. Required: all beats forwarded in order, wlast on the 4th, and s0 bvalid exactly when `m_bvalid`. A new s1 AW is held off until the B handshake.
- Concurrent: s1 read and s0 write overlapping. Required: both complete independently with no stalls caused by the other channel.
- Backpressure: interconnect `m_rvalid` toggles and the granted slave's rready toggles. Required: no beat is lost or duplicated, and the data order is preserved.
- Reset mid-`RD_DATA`: assert rstn=0 asynchronously. Required: `m_arvalid`, `m_rready`, s0 rvalid and s1 rvalid are 0 in the same cycle, and after release s0 wins the first tie.
